l2_arbiter_ctrl: RTL and testbench

Sequential arbiter sharing the single L2 cache port between the L1 instruction cache and the L1 data cache. Requests from both caches are accepted, one is granted with round-robin fairness, and the winner's address, data and command are latched and driven to L2 as registered outputs. The block holds the grant until L2 responds, then routes the response back to the granted cache only. It sits between the two L1 caches and L2, replacing ad-hoc response-tracked muxing with an explicit transaction FSM.

---
 rtl/arb_pkg.sv | 15 +
 rtl/l2_arbiter_ctrl.sv | 132 +++++++++++++
 tb/tb_l2_arbiter_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types for the L2 port arbiter: transaction FSM states and requester select.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } arb_sel_e;

endpackage : arb_pkg

// File: rtl/l2_arbiter_ctrl.sv
// Arbitrates the single L2 port between the L1 I-cache and L1 D-cache.
// Round-robin on collision, winner's command latched into registered L2
// outputs, grant held until L2_resp, response routed to the owner only.
//
// Handshake: a requester raises read and/or write with addr/wdata stable and
// holds them until its arb_*_resp pulse; that pulse is the only acceptance
// signal. L2 sees L2_read/L2_write held stable until it pulses L2_resp for one
// or more cycles; only the first L2_resp cycle of a grant completes it.
module l2_arbiter_ctrl
  import arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_read,
  input  logic              instr_write,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic [LINE_W-1:0] instr_wdata,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [LINE_W-1:0] data_wdata,
  input  logic [LINE_W-1:0] L2_rdata,
  input  logic              L2_resp,
  output logic [ADDR_W-1:0] L2_addr,
  output logic [LINE_W-1:0] L2_wdata,
  output logic              L2_read,
  output logic              L2_write,
  output logic              arb_instr_resp,
  output logic              arb_data_resp,
  output logic [LINE_W-1:0] arb_instr_rdata,
  output logic [LINE_W-1:0] arb_data_rdata,
  output logic [1:0]        dbg_state
);

  arb_state_e state;
  arb_sel_e   last_grant;

  logic              pend_i;
  logic              pend_d;
  logic              grant_any;
  arb_sel_e          winner;
  logic [ADDR_W-1:0] win_addr;
  logic [LINE_W-1:0] win_wdata;
  logic              win_read;
  logic              win_write;

  // Pick a winner while idle; on a collision the side not served last wins.
  always_comb begin
    pend_i    = instr_read | instr_write;
    pend_d    = data_read | data_write;
    grant_any = 1'b0;
    winner    = SEL_I;
    if (state == IDLE) begin
      if (pend_i && pend_d) begin
        grant_any = 1'b1;
        winner    = (last_grant == SEL_I) ? SEL_D : SEL_I;
      end else if (pend_i) begin
        grant_any = 1'b1;
        winner    = SEL_I;
      end else if (pend_d) begin
        grant_any = 1'b1;
        winner    = SEL_D;
      end
    end
  end

  // Select the winner's command; a simultaneous read+write is treated as a write.
  always_comb begin
    win_addr  = instr_addr;
    win_wdata = instr_wdata;
    win_write = instr_write;
    win_read  = instr_read & ~instr_write;
    if (winner == SEL_D) begin
      win_addr  = data_addr;
      win_wdata = data_wdata;
      win_write = data_write;
      win_read  = data_read & ~data_write;
    end
  end

  // Transaction FSM: IDLE -> GRANT_x on a grant, back to IDLE on the first L2_resp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= SEL_I;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state      <= (winner == SEL_I) ? GRANT_I : GRANT_D;
            last_grant <= winner;
          end
        end
        GRANT_I, GRANT_D: begin
          if (L2_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // L2 output registers: load on grant, drop the command when L2 completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      L2_addr  <= '0;
      L2_wdata <= '0;
      L2_read  <= 1'b0;
      L2_write <= 1'b0;
    end else if (grant_any) begin
      L2_addr  <= win_addr;
      L2_wdata <= win_wdata;
      L2_read  <= win_read;
      L2_write <= win_write;
    end else if ((state != IDLE) && L2_resp) begin
      L2_read  <= 1'b0;
      L2_write <= 1'b0;
    end
  end

  // Completion goes to the current owner only; L2_resp while idle is ignored.
  always_comb begin
    arb_instr_resp  = (state == GRANT_I) && L2_resp;
    arb_data_resp   = (state == GRANT_D) && L2_resp;
    arb_instr_rdata = L2_rdata;
    arb_data_rdata  = L2_rdata;
    dbg_state       = state;
  end

endmodule : l2_arbiter_ctrl

// File: tb/tb_l2_arbiter_ctrl.sv
// Directed bench for l2_arbiter_ctrl.
module tb_l2_arbiter_ctrl;
  import arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk;
  logic              rst_n;
  logic              instr_read, instr_write;
  logic [ADDR_W-1:0] instr_addr;
  logic [LINE_W-1:0] instr_wdata;
  logic              data_read, data_write;
  logic [ADDR_W-1:0] data_addr;
  logic [LINE_W-1:0] data_wdata;
  logic [LINE_W-1:0] L2_rdata;
  logic              L2_resp;
  logic [ADDR_W-1:0] L2_addr;
  logic [LINE_W-1:0] L2_wdata;
  logic              L2_read, L2_write;
  logic              arb_instr_resp, arb_data_resp;
  logic [LINE_W-1:0] arb_instr_rdata, arb_data_rdata;
  logic [1:0]        dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  l2_arbiter_ctrl #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_read      (instr_read),
    .instr_write     (instr_write),
    .instr_addr      (instr_addr),
    .instr_wdata     (instr_wdata),
    .data_read       (data_read),
    .data_write      (data_write),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .L2_rdata        (L2_rdata),
    .L2_resp         (L2_resp),
    .L2_addr         (L2_addr),
    .L2_wdata        (L2_wdata),
    .L2_read         (L2_read),
    .L2_write        (L2_write),
    .arb_instr_resp  (arb_instr_resp),
    .arb_data_resp   (arb_data_resp),
    .arb_instr_rdata (arb_instr_rdata),
    .arb_data_rdata  (arb_data_rdata),
    .dbg_state       (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge; inputs set here apply to the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_read  = 1'b0; instr_write = 1'b0;
    instr_addr  = '0;   instr_wdata = '0;
    data_read   = 1'b0; data_write  = 1'b0;
    data_addr   = '0;   data_wdata  = '0;
    L2_rdata    = '0;   L2_resp     = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  // Checks: reset state of every output
  task automatic test_reset();
    do_reset();
    n_cmp++; if (L2_read !== 1'b0) begin n_err++; $display("FAIL reset_L2_read: got %0b want 0", L2_read); end
    n_cmp++; if (L2_write !== 1'b0) begin n_err++; $display("FAIL reset_L2_write: got %0b want 0", L2_write); end
    n_cmp++; if (L2_addr !== '0) begin n_err++; $display("FAIL reset_L2_addr: got %h want 0", L2_addr); end
    n_cmp++; if (L2_wdata !== '0) begin n_err++; $display("FAIL reset_L2_wdata: got %h want 0", L2_wdata); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    L2_resp = 1'b1;
    #1;
    n_cmp++; if ({arb_instr_resp, arb_data_resp} !== 2'b00) begin n_err++; $display("FAIL reset_idle_resp_ignored: got %b want 00", {arb_instr_resp, arb_data_resp}); end
    L2_resp = 1'b0;
  endtask

  // Lone I-cache read, 5-cycle L2 latency, held L2_resp only counts once
  task automatic test_lone_iread();
    logic [LINE_W-1:0] rd;
    rd = {8{32'hA5A5_1234}};
    do_reset();
    instr_read = 1'b1;
    instr_addr = 32'h0000_1000;
    #1;
    n_cmp++; if (L2_read !== 1'b0) begin n_err++; $display("FAIL lone_not_before_edge: got %0b want 0", L2_read); end
    tick();
    n_cmp++; if (L2_read !== 1'b1) begin n_err++; $display("FAIL lone_L2_read: got %0b want 1", L2_read); end
    n_cmp++; if (L2_write !== 1'b0) begin n_err++; $display("FAIL lone_L2_write: got %0b want 0", L2_write); end
    n_cmp++; if (L2_addr !== 32'h0000_1000) begin n_err++; $display("FAIL lone_L2_addr: got %h want 00001000", L2_addr); end
    n_cmp++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL lone_state: got %0d want 1", dbg_state); end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (L2_read !== 1'b1) begin n_err++; $display("FAIL lone_cmd_held: got %0b want 1", L2_read); end
    L2_resp = 1'b1;
    L2_rdata = rd;
    instr_read = 1'b0;
    #1;
    n_cmp++; if (arb_instr_resp !== 1'b1) begin n_err++; $display("FAIL lone_instr_resp: got %0b want 1", arb_instr_resp); end
    n_cmp++; if (arb_data_resp !== 1'b0) begin n_err++; $display("FAIL lone_data_resp: got %0b want 0", arb_data_resp); end
    n_cmp++; if (arb_instr_rdata !== rd) begin n_err++; $display("FAIL lone_rdata: got %h want %h", arb_instr_rdata, rd); end
    tick();
    // L2_resp still high in IDLE: must be ignored
    n_cmp++; if (arb_instr_resp !== 1'b0) begin n_err++; $display("FAIL lone_resp_pulse: got %0b want 0", arb_instr_resp); end
    n_cmp++; if (L2_read !== 1'b0) begin n_err++; $display("FAIL lone_cmd_dropped: got %0b want 0", L2_read); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL lone_back_idle: got %0d want 0", dbg_state); end
    L2_resp = 1'b0;
  endtask

  // Collision from reset: D first, one idle cycle, then I
  task automatic test_collision();
    logic [LINE_W-1:0] wd;
    wd = {8{32'hCAFE_0200}};
    do_reset();
    instr_read = 1'b1; instr_addr = 32'h100;
    data_write = 1'b1; data_addr  = 32'h200; data_wdata = wd;
    tick();
    n_cmp++; if ({L2_write, L2_read} !== 2'b10) begin n_err++; $display("FAIL coll_d_cmd: got %b want 10", {L2_write, L2_read}); end
    n_cmp++; if (L2_addr !== 32'h200) begin n_err++; $display("FAIL coll_d_addr: got %h want 00000200", L2_addr); end
    n_cmp++; if (L2_wdata !== wd) begin n_err++; $display("FAIL coll_d_wdata: got %h want %h", L2_wdata, wd); end
    L2_resp = 1'b1; data_write = 1'b0;
    #1;
    n_cmp++; if ({arb_instr_resp, arb_data_resp} !== 2'b01) begin n_err++; $display("FAIL coll_d_resp: got %b want 01", {arb_instr_resp, arb_data_resp}); end
    tick();
    L2_resp = 1'b0;
    n_cmp++; if ({L2_write, L2_read, dbg_state} !== 4'b0000) begin n_err++; $display("FAIL coll_idle_gap: got %b want 0000", {L2_write, L2_read, dbg_state}); end
    tick();
    n_cmp++; if ({L2_read, dbg_state} !== 3'b101) begin n_err++; $display("FAIL coll_i_grant: got %b want 101", {L2_read, dbg_state}); end
    n_cmp++; if (L2_addr !== 32'h100) begin n_err++; $display("FAIL coll_i_addr: got %h want 00000100", L2_addr); end
    L2_resp = 1'b1; instr_read = 1'b0;
    tick();
    L2_resp = 1'b0;
  endtask

  // Both held continuously: grants alternate D,I,D,I,D,I
  task automatic test_back_to_back();
    logic [1:0] exp_state;
    do_reset();
    instr_read = 1'b1; instr_addr = 32'h300;
    data_read  = 1'b1; data_addr  = 32'h400;
    tick();
    for (int t = 0; t < 6; t++) begin
      exp_state = (t % 2 == 0) ? 2'd2 : 2'd1;
      n_cmp++; if (dbg_state !== exp_state) begin n_err++; $display("FAIL b2b_grant_%0d: got %0d want %0d", t, dbg_state, exp_state); end
      n_cmp++; if (L2_addr !== ((t % 2 == 0) ? 32'h400 : 32'h300)) begin n_err++; $display("FAIL b2b_addr_%0d: got %h", t, L2_addr); end
      L2_resp = 1'b1;
      if (t == 5) begin instr_read = 1'b0; data_read = 1'b0; end
      #1;
      n_cmp++; if ({arb_instr_resp, arb_data_resp} !== ((t % 2 == 0) ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL b2b_resp_%0d: got %b", t, {arb_instr_resp, arb_data_resp}); end
      tick();
      L2_resp = 1'b0;
      tick();
    end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL b2b_end_idle: got %0d want 0", dbg_state); end
  endtask

  // Requester input changes during a grant do not reach L2
  task automatic test_addr_hold();
    do_reset();
    data_read = 1'b1; data_addr = 32'h500;
    tick();
    data_addr = 32'hDEAD; data_read = 1'b0; data_write = 1'b1;
    data_wdata = {8{32'h1111_2222}};
    tick();
    tick();
    n_cmp++; if (L2_addr !== 32'h500) begin n_err++; $display("FAIL hold_addr: got %h want 00000500", L2_addr); end
    n_cmp++; if ({L2_read, L2_write} !== 2'b10) begin n_err++; $display("FAIL hold_cmd: got %b want 10", {L2_read, L2_write}); end
    n_cmp++; if (L2_wdata !== '0) begin n_err++; $display("FAIL hold_wdata: got %h want 0", L2_wdata); end
    data_write = 1'b0;
    L2_resp = 1'b1;
    tick();
    L2_resp = 1'b0;
  endtask

  // Reset mid GRANT_I abandons the transaction
  task automatic test_reset_mid();
    do_reset();
    instr_read = 1'b1; instr_addr = 32'h700;
    tick();
    n_cmp++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL rstmid_pre_grant: got %0d want 1", dbg_state); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({L2_read, L2_write, dbg_state} !== 4'b0000) begin n_err++; $display("FAIL rstmid_async: got %b want 0000", {L2_read, L2_write, dbg_state}); end
    n_cmp++; if (L2_addr !== '0) begin n_err++; $display("FAIL rstmid_addr: got %h want 0", L2_addr); end
    instr_read = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    L2_resp = 1'b1;
    #1;
    n_cmp++; if ({arb_instr_resp, arb_data_resp} !== 2'b00) begin n_err++; $display("FAIL rstmid_late_resp: got %b want 00", {arb_instr_resp, arb_data_resp}); end
    tick();
    L2_resp = 1'b0;
  endtask

  // Read and write together: write wins
  task automatic test_rw_both();
    do_reset();
    data_read = 1'b1; data_write = 1'b1; data_addr = 32'h40;
    tick();
    n_cmp++; if ({L2_write, L2_read} !== 2'b10) begin n_err++; $display("FAIL rw_cmd: got %b want 10", {L2_write, L2_read}); end
    n_cmp++; if (L2_addr !== 32'h40) begin n_err++; $display("FAIL rw_addr: got %h want 00000040", L2_addr); end
    L2_resp = 1'b1; data_read = 1'b0; data_write = 1'b0;
    tick();
    L2_resp = 1'b0;
  endtask

  // Sequence and final report
  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_lone_iread();
    test_collision();
    test_back_to_back();
    test_addr_hold();
    test_reset_mid();
    test_rw_both();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_l2_arbiter_ctrl
